// File: rtl/input_limit_pkg.sv
// Shared types, constants and the golden response function for the
// LUT input-limit stimulus checker.
package input_limit_pkg;

    localparam int RESP_W = 8;
    localparam int IDX_W  = 24;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Expected DUT response, packed as {out2[3:0], out[3:0]}.
    // Every bit except bit 0 is gated by a[0].
    function automatic logic [RESP_W-1:0] golden_resp(input logic [31:0] a,
                                                      input logic [31:0] b);
        logic [RESP_W-1:0] r;
        r[0] = |a[5:0];
        r[1] = (&a[11:6]) & a[0];
        r[2] = (^a[17:12]) & a[0];
        r[3] = ~(|a[23:18]) & a[0];
        r[4] = ~(&b[5:1]) & a[0];
        r[5] = ~b[11] & (^b[10:7]) & a[0];
        r[6] = ~(^b[17:13]) & a[0];
        r[7] = (|b[23:22]) & (|b[20:18]) & a[0];
        return r;
    endfunction

    // One Galois LFSR step; both stimulus buses use the same mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/input_limit_golden.sv
// Combinational wrapper around golden_resp so the same model can be
// instantiated as a loopback DUT or scoreboard.
import input_limit_pkg::*;

module input_limit_golden (
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic [RESP_W-1:0] resp
);

    // Pure function of the current stimulus pair.
    always_comb begin
        resp = golden_resp(a, b);
    end

endmodule

// File: rtl/input_limit_stim_checker.sv
// Stimulus generator and response checker for the LUT input-limit block.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one vector issued per cycle, indices 0..NUM_VECTORS-1
// DRAIN | last vector held while the delay pipeline empties
// DONE  | results held, pass valid; start begins a new run
import input_limit_pkg::*;

module input_limit_stim_checker #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned DUT_LATENCY = 0,
    parameter logic [31:0] SEED_A      = 32'h0000_0001,
    parameter logic [31:0] SEED_B      = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic [31:0]       stim_a,
    output logic [31:0]       stim_b,
    input  logic [RESP_W-1:0] dut_resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [RESP_W-1:0] first_err_got,
    output logic [RESP_W-1:0] first_err_exp
);

    localparam int DEPTH = DUT_LATENCY + 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
    localparam logic [2:0]       DRAIN_LOAD = 3'(DUT_LATENCY);

    state_t state_q, state_d;

    logic              accept, advance, drain_start, to_done, issue;
    logic              mode_q;
    logic [IDX_W-1:0]  cur_idx, nxt_idx;
    logic [31:0]       nxt_a, nxt_b;
    logic [RESP_W-1:0] nxt_exp;
    logic [2:0]        drain_cnt;
    logic              done_q;
    logic              mismatch;

    logic              pipe_vld [DEPTH];
    logic [IDX_W-1:0]  pipe_idx [DEPTH];
    logic [RESP_W-1:0] pipe_exp [DEPTH];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; the index compare is on the vector now on the bus,
    // so a full 2^24 run ends exactly at index 24'hFFFFFF without wrapping.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        advance     = 1'b0;
        drain_start = 1'b0;
        to_done     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (cur_idx == LAST_IDX) begin
                    state_d     = DRAIN;
                    drain_start = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 3'd0) begin
                    state_d = DONE;
                    to_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue = accept | advance;

    // Next vector: first vector on accept, then counter or LFSR step.
    always_comb begin
        nxt_idx = cur_idx;
        nxt_a   = stim_a;
        nxt_b   = stim_b;
        if (accept) begin
            nxt_idx = '0;
            if (mode) begin
                nxt_a = SEED_A;
                nxt_b = SEED_B;
            end else begin
                nxt_a = 32'h0000_0000;
                nxt_b = 32'hFFFF_FFFF;
            end
        end else if (advance) begin
            nxt_idx = cur_idx + IDX_W'(1);
            if (mode_q) begin
                nxt_a = lfsr_step(stim_a);
                nxt_b = lfsr_step(stim_b);
            end else begin
                nxt_a = {8'h00, nxt_idx};
                nxt_b = ~{8'h00, nxt_idx};
            end
        end
    end

    input_limit_golden u_golden (
        .a    (nxt_a),
        .b    (nxt_b),
        .resp (nxt_exp)
    );

    // Stimulus registers, index, latched mode and drain down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stim_a    <= '0;
            stim_b    <= '0;
            cur_idx   <= '0;
            mode_q    <= 1'b0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            if (issue) begin
                stim_a  <= nxt_a;
                stim_b  <= nxt_b;
                cur_idx <= nxt_idx;
            end
            if (accept) begin
                mode_q <= mode;
            end
            if (drain_start) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state_q == DRAIN && drain_cnt != 3'd0) begin
                drain_cnt <= drain_cnt - 3'd1;
            end
            done_q <= to_done;
        end
    end

    // {valid, idx, exp} delay line; stage 0 lines up with stim_a/stim_b.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_idx[k] <= '0;
                pipe_exp[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            pipe_idx[0] <= nxt_idx;
            pipe_exp[0] <= nxt_exp;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_idx[k] <= pipe_idx[k-1];
                pipe_exp[k] <= pipe_exp[k-1];
            end
        end
    end

    assign mismatch = pipe_vld[DEPTH-1] && (dut_resp != pipe_exp[DEPTH-1]);

    // Error count saturates; only the first mismatch of a run is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (accept) begin
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (mismatch) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (err_count == 16'd0) begin
                first_err_idx <= pipe_idx[DEPTH-1];
                first_err_got <= dut_resp;
                first_err_exp <= pipe_exp[DEPTH-1];
            end
        end
    end

    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = done_q;
    assign pass = (state_q == DONE) && (err_count == 16'd0);

endmodule

// File: tb/tb_input_limit_stim_checker.sv
// Directed bench: golden vector table plus multi-cycle run sequences on
// three checker instances (loopback, two-cycle DUT, saturating run).
import input_limit_pkg::*;

module tb_input_limit_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- golden table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  exp;
    } gvec_t;

    gvec_t       tbl [9];
    logic [31:0] tbl_a = '0;
    logic [31:0] tbl_b = '0;
    logic [7:0]  tbl_resp;

    input_limit_golden u_gold_tbl (.a(tbl_a), .b(tbl_b), .resp(tbl_resp));

    // ---------------- instance 0: loopback, N=256, L=0 ----------------
    logic        rst0 = 1'b1, start0 = 1'b0, mode0 = 1'b0, stuck0 = 1'b0;
    logic [31:0] stim_a0, stim_b0;
    logic [7:0]  gold0, resp0;
    logic        busy0, done0, pass0;
    logic [15:0] err0;
    logic [23:0] fidx0;
    logic [7:0]  fgot0, fexp0;

    input_limit_golden u_lb0 (.a(stim_a0), .b(stim_b0), .resp(gold0));
    assign resp0 = stuck0 ? (gold0 & 8'hFE) : gold0;

    input_limit_stim_checker #(.NUM_VECTORS(256), .DUT_LATENCY(0)) u0 (
        .clk(clk), .reset(rst0), .start(start0), .mode(mode0),
        .stim_a(stim_a0), .stim_b(stim_b0), .dut_resp(resp0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_idx(fidx0), .first_err_got(fgot0), .first_err_exp(fexp0)
    );

    // ---------------- instance 1: DUT registered twice, N=64, L=2 ----------------
    logic        rst1 = 1'b1, start1 = 1'b0, mode1 = 1'b0;
    logic [31:0] stim_a1, stim_b1;
    logic [7:0]  gold1, r1a = '0, r1b = '0;
    logic        busy1, done1, pass1;
    logic [15:0] err1;
    logic [23:0] fidx1;
    logic [7:0]  fgot1, fexp1;

    input_limit_golden u_lb1 (.a(stim_a1), .b(stim_b1), .resp(gold1));
    always @(posedge clk) begin
        r1a <= gold1;
        r1b <= r1a;
    end

    input_limit_stim_checker #(.NUM_VECTORS(64), .DUT_LATENCY(2)) u1 (
        .clk(clk), .reset(rst1), .start(start1), .mode(mode1),
        .stim_a(stim_a1), .stim_b(stim_b1), .dut_resp(r1b),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_idx(fidx1), .first_err_got(fgot1), .first_err_exp(fexp1)
    );

    // ---------------- instance 2: inverted response, N=70000 ----------------
    logic        rst2 = 1'b1, start2 = 1'b0, mode2 = 1'b0;
    logic [31:0] stim_a2, stim_b2;
    logic [7:0]  gold2, resp2;
    logic        busy2, done2, pass2;
    logic [15:0] err2;
    logic [23:0] fidx2;
    logic [7:0]  fgot2, fexp2;
    int          cyc2 = 0;
    int          u2_at = -1;
    logic        u2_fin = 1'b0;

    input_limit_golden u_lb2 (.a(stim_a2), .b(stim_b2), .resp(gold2));
    assign resp2 = ~gold2;

    input_limit_stim_checker #(.NUM_VECTORS(70000), .DUT_LATENCY(0)) u2 (
        .clk(clk), .reset(rst2), .start(start2), .mode(mode2),
        .stim_a(stim_a2), .stim_b(stim_b2), .dut_resp(resp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_idx(fidx2), .first_err_got(fgot2), .first_err_exp(fexp2)
    );

    // Long saturating run proceeds alongside the main sequence.
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rst2 = 1'b0;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0; cyc2 = 1;
        while (!done2 && cyc2 < 71000) begin
            @(posedge clk); #1 cyc2++;
        end
        u2_at  = done2 ? cyc2 : -1;
        u2_fin = 1'b1;
    end

    // ---------------- helpers for instance 0 ----------------
    int cyc0 = 0;

    task automatic pulse_start0(input logic m);
        @(negedge clk);
        start0 = 1'b1;
        mode0  = m;
        @(posedge clk); #1;
        start0 = 1'b0;
        cyc0   = 1;
    endtask

    task automatic step0();
        @(posedge clk); #1;
        cyc0++;
    endtask

    task automatic wait_done0(output int at);
        while (!done0 && cyc0 < 400) step0();
        at = done0 ? cyc0 : -1;
    endtask

    // ---------------- main sequence ----------------
    int at;
    int cyc1;
    int guard;

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0000_0000, 8'h00};
        tbl[1] = '{32'h0000_0001, 32'hFFFF_FFFE, 8'h89};
        tbl[2] = '{32'h0000_0001, 32'h0000_0000, 8'h59};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h83};
        tbl[4] = '{32'h0000_1001, 32'h0000_0080, 8'h7D};
        tbl[5] = '{32'h0000_0FC1, 32'h0044_0000, 8'hDB};
        tbl[6] = '{32'h00FC_0001, 32'h0000_003E, 8'h41};
        tbl[7] = '{32'h0000_003E, 32'hFFFF_FFFF, 8'h01};
        tbl[8] = '{32'h0000_0001, 32'h0000_E000, 8'h19};

        for (int i = 0; i < 9; i++) begin
            tbl_a = tbl[i].a;
            tbl_b = tbl[i].b;
            #1;
            check($sformatf("golden[%0d]", i), 32'(tbl_resp), 32'(tbl[i].exp));
        end

        // reset state of instance 0
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_stim_a", stim_a0, 32'd0);
        check("rst_stim_b", stim_b0, 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        @(negedge clk) rst0 = 1'b0;

        // clean counter-mode run
        stuck0 = 1'b0;
        pulse_start0(1'b0);
        check("t1_stim_a_c1", stim_a0, 32'h0000_0000);
        check("t1_stim_b_c1", stim_b0, 32'hFFFF_FFFF);
        check("t1_busy", 32'(busy0), 32'd1);
        step0();
        check("t1_stim_a_c2", stim_a0, 32'h0000_0001);
        check("t1_stim_b_c2", stim_b0, 32'hFFFF_FFFE);
        wait_done0(at);
        check("t1_done_cycle", 32'(at), 32'd258);
        check("t1_pass", 32'(pass0), 32'd1);
        check("t1_err", 32'(err0), 32'd0);
        check("t1_busy_done", 32'(busy0), 32'd0);
        step0();
        check("t1_done_pulse", 32'(done0), 32'd0);
        check("t1_pass_held", 32'(pass0), 32'd1);

        // dut_resp[0] stuck at 0, restart from DONE
        stuck0 = 1'b1;
        pulse_start0(1'b0);
        wait_done0(at);
        check("t2_done_cycle", 32'(at), 32'd258);
        check("t2_first_idx", 32'(fidx0), 32'd1);
        check("t2_first_exp", 32'(fexp0), 32'h89);
        check("t2_first_got", 32'(fgot0), 32'h88);
        check("t2_pass", 32'(pass0), 32'd0);
        check("t2_err", 32'(err0), 32'd252);

        // second start and mode change during a run are ignored
        stuck0 = 1'b0;
        pulse_start0(1'b0);
        while (cyc0 < 10) step0();
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0; cyc0++;
        check("t5_busy", 32'(busy0), 32'd1);
        check("t5_stim_c11", stim_a0, 32'd10);
        @(negedge clk) mode0 = 1'b1;
        while (cyc0 < 30) step0();
        check("t5_stim_c30", stim_a0, 32'd29);
        check("t5_stim_b_c30", stim_b0, ~32'd29);
        wait_done0(at);
        check("t5_done_cycle", 32'(at), 32'd258);
        check("t5_pass", 32'(pass0), 32'd1);
        mode0 = 1'b0;

        // reset in the middle of a failing run
        stuck0 = 1'b1;
        pulse_start0(1'b0);
        while (cyc0 < 50) step0();
        check("t6_err_c50", 32'(err0), 32'd48);
        @(negedge clk) rst0 = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_stim_a", stim_a0, 32'd0);
        check("t6_rst_stim_b", stim_b0, 32'd0);
        check("t6_rst_busy", 32'(busy0), 32'd0);
        check("t6_rst_done", 32'(done0), 32'd0);
        check("t6_rst_pass", 32'(pass0), 32'd0);
        check("t6_rst_err", 32'(err0), 32'd0);
        check("t6_rst_fidx", 32'(fidx0), 32'd0);
        check("t6_rst_fgot", 32'(fgot0), 32'd0);
        check("t6_rst_fexp", 32'(fexp0), 32'd0);
        @(negedge clk) rst0 = 1'b0;
        step0();
        step0();
        check("t6_idle_busy", 32'(busy0), 32'd0);
        stuck0 = 1'b0;
        pulse_start0(1'b0);
        wait_done0(at);
        check("t6_done_cycle", 32'(at), 32'd258);
        check("t6_pass", 32'(pass0), 32'd1);
        check("t6_err", 32'(err0), 32'd0);

        // LFSR mode through a two-cycle DUT
        @(negedge clk) rst1 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        mode1  = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        mode1  = 1'b0;
        cyc1   = 1;
        check("t3_a_v0", stim_a1, 32'h0000_0001);
        check("t3_b_v0", stim_b1, 32'hDEAD_BEEF);
        @(posedge clk); #1 cyc1++;
        check("t3_a_v1", stim_a1, 32'h8020_0003);
        check("t3_b_v1", stim_b1, 32'hEF76_DF74);
        @(posedge clk); #1 cyc1++;
        check("t3_a_v2", stim_a1, 32'hC030_0002);
        check("t3_b_v2", stim_b1, 32'h77BB_6FBA);
        @(posedge clk); #1 cyc1++;
        check("t3_a_v3", stim_a1, 32'h6018_0001);
        @(posedge clk); #1 cyc1++;
        check("t3_a_v4", stim_a1, 32'hB02C_0003);
        while (!done1 && cyc1 < 200) begin
            @(posedge clk); #1 cyc1++;
        end
        check("t3_done_cycle", done1 ? 32'(cyc1) : 32'hFFFF_FFFF, 32'd68);
        check("t3_pass", 32'(pass1), 32'd1);
        check("t3_err", 32'(err1), 32'd0);

        // saturating run results
        guard = 0;
        while (!u2_fin && guard < 80000) begin
            @(posedge clk);
            guard++;
        end
        check("t4_done_cycle", 32'(u2_at), 32'd70002);
        check("t4_err_sat", 32'(err2), 32'h0000_FFFF);
        check("t4_first_idx", 32'(fidx2), 32'd0);
        check("t4_first_exp", 32'(fexp2), 32'h00);
        check("t4_first_got", 32'(fgot2), 32'hFF);
        check("t4_pass", 32'(pass2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_limit_stim_checker.md
Name: input_limit_stim_checker

Overview:
- Sequential stimulus generator and response checker for the LUT input-limit experiment block.
- Drives the DUT's two 32-bit input buses and samples its 8-bit response. Compares each response against an internal golden model and reports pass/fail, error count and the first failing vector.
- Sits on the stimulus side of the DUT in the on-board test harness. Lets the carry/LUT study run without an external pattern source.

Parameters:
- NUM_VECTORS, 256, vectors issued per run (1 to 2^24).
- DUT_LATENCY, 0, cycles from stim_a/stim_b change to valid dut_resp (0 to 4).
- SEED_A, 32'h0000_0001, LFSR seed for stim_a in mode 1 (nonzero).
- SEED_B, 32'hDEAD_BEEF, LFSR seed for stim_b in mode 1 (nonzero).

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a run; ignored unless state is IDLE or DONE
- mode  in  1  stimulus source: 0 = counter, 1 = LFSR; sampled on accepted start
- stim_a  out  32  DUT input bus "in" (registered)
- stim_b  out  32  DUT input bus "in2" (registered)
- dut_resp  in  8  DUT response packed as {out2[3:0], out[3:0]}
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse on entry to DONE
- pass  out  1  valid in DONE; 1 when err_count == 0
- err_count  out  16  number of mismatching vectors, saturates at 16'hFFFF
- first_err_idx  out  24  index of the first mismatching vector
- first_err_got  out  8  dut_resp captured at the first mismatch
- first_err_exp  out  8  expected value at the first mismatch

Behaviour:
- Reset, synchronous active-high. Effective in any state, including mid-run. Result:
  - state = IDLE
  - stim_a = stim_b = 0
  - busy = done = pass = 0
  - err_count, first_err_* = 0
  - delay pipeline cleared
  - idx = 0
- States:
  - IDLE: on start, go to RUN; clear err_count and first_err_*; latch mode; idx = 0.
  - RUN: issue one vector per cycle. After vector NUM_VECTORS-1 is issued, go to DRAIN.
  - DRAIN: hold the last stimulus; stay DUT_LATENCY+1 cycles.
  - DONE: pass valid, results held. On start, go to RUN (same as IDLE).
- Counter mode, vector i: stim_a = {8'h00, i[23:0]}, stim_b = ~stim_a.
- LFSR mode:
  - Vector 0 = SEED_A / SEED_B.
  - Each next vector is one Galois step, mask 32'h8020_0003: if lsb, v = (v >> 1) ^ mask, else v >> 1.
  - The same mask is used for both buses.
- Golden model, combinational on the issued vector, with a = stim_a and b = stim_b:
  - exp[0] = OR of a[5:0]
  - exp[1] = AND of a[11:6], AND a[0]
  - exp[2] = XOR of a[17:12], AND a[0]
  - exp[3] = NOR of a[23:18], AND a[0]
  - exp[4] = NAND of b[5:1], AND a[0]
  - exp[5] = NOT b[11], AND XOR of b[10:7], AND a[0]
  - exp[6] = XNOR of b[17:13], AND a[0]
  - exp[7] = (OR of b[23:22]) AND (OR of b[20:18]) AND a[0]
- Alignment:
  - {valid, idx, exp} travels through a DUT_LATENCY+1 stage shift register.
  - Stage 0 is aligned with the registered stim output.
  - Compare dut_resp against the tail of the register when valid = 1.
- On mismatch:
  - err_count increments, saturating at 16'hFFFF.
  - If it is the first mismatch of the run, capture idx, dut_resp and exp.
  - Later mismatches never overwrite the first_err_* captures.
- Latency: from the accepted start edge, done pulses at cycle NUM_VECTORS + DUT_LATENCY + 2.
- start while busy is ignored: no restart and no state change.
- mode changes mid-run have no effect.
- Index width is 24 bits. NUM_VECTORS = 2^24 is legal: the last index is 24'hFFFFFF and the check must not wrap early.

Decomposition:
- Package input_limit_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - LFSR_MASK = 32'h8020_0003
  - RESP_W = 8, IDX_W = 24
  - a function golden_resp(a, b) returning 8 bits
- One sub-module, input_limit_golden: a combinational wrapper around golden_resp, reused by the bench as its scoreboard.

Test Plan:
- Loopback golden model as DUT, NUM_VECTORS = 256, mode 0, latency 0 -> done at cycle 258, pass = 1, err_count = 0.
- Same as above with dut_resp[0] stuck at 0 -> first_err_idx = 1, first_err_exp = 8'h89, first_err_got = 8'h88, pass = 0.
- DUT registered twice, DUT_LATENCY = 2, mode 1 -> pass = 1. Cycle after start: stim_a = 32'h0000_0001, next stim_a = 32'h8020_0003.
- NUM_VECTORS = 70000, dut_resp = ~exp -> err_count = 16'hFFFF (saturated), first_err_idx = 0.
- Second start pulse at RUN cycle 10 -> ignored; done at the original cycle.
- Reset asserted mid-run at cycle 50, then start -> all outputs return to 0, then a full clean run passes.
